simple_timer: RTL and testbench

- Bus-mapped 16-bit programmable timer on the cpu68 data/address bus, decoded by the top-level at 0xE7xx.
- Sits directly upstream of the CPU interrupt input: its irq output replaces the raw RTC square wave currently driving sys_irq.
- Provides a prescaled free-running counter, output compare with optional auto-reload, overflow flag and maskable interrupt.
- Read data feeds the top-level data-in multiplexer alongside the boot ROM, boot RAM and simpleio read data.

---
 rtl/timer_pkg.sv | 24 ++
 rtl/timer_prescaler.sv | 27 ++
 rtl/simple_timer.sv | 156 +++++++++++++++
 tb/tb_simple_timer.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared register map and bit positions for the bus-mapped simple_timer.
package timer_pkg;

  localparam logic [3:0] REG_CTRL  = 4'd0;
  localparam logic [3:0] REG_STAT  = 4'd1;
  localparam logic [3:0] REG_PRESC = 4'd2;
  localparam logic [3:0] REG_CNT_H = 4'd3;
  localparam logic [3:0] REG_CNT_L = 4'd4;
  localparam logic [3:0] REG_CMP_H = 4'd5;
  localparam logic [3:0] REG_CMP_L = 4'd6;
  localparam logic [3:0] REG_CAP_H = 4'd7;
  localparam logic [3:0] REG_CAP_L = 4'd8;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_OCIE = 1;
  localparam int CTRL_TOIE = 2;
  localparam int CTRL_ARLD = 3;
  localparam int CTRL_ICIE = 4;

  localparam int STAT_OCF = 0;
  localparam int STAT_TOF = 1;
  localparam int STAT_ICF = 2;

endpackage

// File: rtl/timer_prescaler.sv
// Divides clk by (divisor+1): tick is high for one clk each time the count reaches divisor.
module timer_prescaler #(
  parameter int PRESC_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [PRESC_W-1:0] divisor,
  input  logic               clear,
  output logic               tick
);

  logic [PRESC_W-1:0] count;

  assign tick = en & (count == divisor);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      count <= tick ? '0 : count + {{(PRESC_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/simple_timer.sv
// 16-bit prescaled timer with output compare, overflow flag and maskable irq.
// Input capture (cap_in port, CAP registers, ICF/ICIE) exists only with TIMER_CAPTURE_EN.
module simple_timer
  import timer_pkg::*;
#(
  parameter int          PRESC_W   = 8,
  parameter logic [15:0] CNT_RESET = 16'h0000,
  parameter logic [15:0] CMP_RESET = 16'hFFFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] Address,
  input  logic [7:0] DI,
  output logic [7:0] DO,
  input  logic       rw,
  input  logic       cs,
  output logic       irq
`ifdef TIMER_CAPTURE_EN
  ,
  input  logic       cap_in
`endif
);

`ifdef TIMER_CAPTURE_EN
  localparam logic [4:0] CTRL_MASK = 5'h1F;
`else
  localparam logic [4:0] CTRL_MASK = 5'h0F;
`endif

  // Bus: single-cycle access, no wait states. cs=1 & rw=0 commits a write at
  // the posedge; cs=1 & rw=1 applies read side effects (byte latches) at the
  // posedge while DO shows the addressed register combinationally.
  logic wr, rd;
  assign wr = cs & ~rw;
  assign rd = cs & rw;

  logic [4:0]         ctrl;
  logic [2:0]         stat;
  logic [PRESC_W-1:0] presc;
  logic [15:0]        cnt, cmp;
  logic [7:0]         cnt_lat, cnt_wbuf, cmp_wbuf;
  logic               tick, presc_clear;
  logic               cnt_l_wr, cnt_tick, match;
  logic [2:0]         stat_set, stat_clr;
  logic               cap_set;

  assign cnt_l_wr    = wr & (Address == REG_CNT_L);
  assign presc_clear = wr & ((Address == REG_PRESC) | (Address == REG_CNT_L));
  // A CNT_L load overrides the tick that lands in the same cycle.
  assign cnt_tick    = tick & ~cnt_l_wr;
  assign match       = (cnt == cmp);

  timer_prescaler #(.PRESC_W(PRESC_W)) u_presc (
    .clk     (clk),
    .rst     (rst),
    .en      (ctrl[CTRL_EN]),
    .divisor (presc),
    .clear   (presc_clear),
    .tick    (tick)
  );

  always_comb begin
    stat_set           = '0;
    stat_set[STAT_OCF] = cnt_tick & match;
    stat_set[STAT_TOF] = cnt_tick & ~match & (cnt == 16'hFFFF);
    stat_set[STAT_ICF] = cap_set;
  end

  assign stat_clr = (wr && Address == REG_STAT) ? DI[2:0] : 3'b000;

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl     <= '0;
      stat     <= '0;
      presc    <= '0;
      cnt      <= CNT_RESET;
      cmp      <= CMP_RESET;
      cnt_lat  <= '0;
      cnt_wbuf <= '0;
      cmp_wbuf <= '0;
    end else begin
      // Hardware set beats a coincident write-1-clear.
      stat <= (stat & ~stat_clr) | stat_set;

      if (wr) begin
        case (Address)
          REG_CTRL:  ctrl     <= DI[4:0] & CTRL_MASK;
          REG_PRESC: presc    <= PRESC_W'(DI);
          REG_CNT_H: cnt_wbuf <= DI;
          REG_CMP_H: cmp_wbuf <= DI;
          REG_CMP_L: cmp      <= {cmp_wbuf, DI};
          default: ;
        endcase
      end

      if (rd && Address == REG_CNT_H) cnt_lat <= cnt[7:0];

      if (cnt_l_wr) begin
        cnt <= {cnt_wbuf, DI};
      end else if (tick) begin
        cnt <= (match && ctrl[CTRL_ARLD]) ? 16'h0000 : cnt + 16'd1;
      end
    end
  end

`ifdef TIMER_CAPTURE_EN
  logic [2:0]  cap_sync;
  logic [15:0] cap;
  logic [7:0]  cap_lat;

  // cap_sync[1:0] is the synchroniser; cap_sync[2] holds the previous value for edge detect.
  assign cap_set = cap_sync[1] & ~cap_sync[2];

  always_ff @(posedge clk) begin
    if (rst) begin
      cap_sync <= '0;
      cap      <= '0;
      cap_lat  <= '0;
    end else begin
      cap_sync <= {cap_sync[1:0], cap_in};
      if (cap_set) cap <= cnt;
      if (rd && Address == REG_CAP_H) cap_lat <= cap[7:0];
    end
  end
`else
  assign cap_set = 1'b0;
`endif

  always_comb begin
    DO = 8'h00;
    if (cs) begin
      case (Address)
        REG_CTRL:  DO = {3'b000, ctrl};
        REG_STAT:  DO = {5'b00000, stat};
        REG_PRESC: DO = 8'(presc);
        REG_CNT_H: DO = cnt[15:8];
        REG_CNT_L: DO = cnt_lat;
        REG_CMP_H: DO = cmp[15:8];
        REG_CMP_L: DO = cmp[7:0];
`ifdef TIMER_CAPTURE_EN
        REG_CAP_H: DO = cap[15:8];
        REG_CAP_L: DO = cap_lat;
`else
        REG_CAP_H: DO = 8'h00;
        REG_CAP_L: DO = 8'h00;
`endif
        default:   DO = 8'h00;
      endcase
    end
  end

  assign irq = (stat[STAT_OCF] & ctrl[CTRL_OCIE]) |
               (stat[STAT_TOF] & ctrl[CTRL_TOIE]) |
               (stat[STAT_ICF] & ctrl[CTRL_ICIE]);

endmodule

// File: tb/tb_simple_timer.sv
// Bench for simple_timer: directed scenarios plus random bus traffic against a register-level model.
module tb_simple_timer;

  logic       clk;
  logic       rst;
  logic [3:0] Address;
  logic [7:0] DI;
  logic [7:0] DO;
  logic       rw;
  logic       cs;
  logic       irq;
`ifdef TIMER_CAPTURE_EN
  logic       cap_in;
  localparam int CTRL_MASK_TB = 'h1F;
`else
  localparam int CTRL_MASK_TB = 'h0F;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state, kept as plain integers.
  int m_ctrl, m_stat, m_presc, m_phase;
  int m_cnt, m_cmp, m_lat, m_wb_cnt, m_wb_cmp;
  int m_cap, m_cap_lat, m_hist;

  logic [7:0] do_seen;
  logic       irq_seen;

  simple_timer dut (
    .clk     (clk),
    .rst     (rst),
    .Address (Address),
    .DI      (DI),
    .DO      (DO),
    .rw      (rw),
    .cs      (cs),
    .irq     (irq)
`ifdef TIMER_CAPTURE_EN
    ,
    .cap_in  (cap_in)
`endif
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ctrl = 0; m_stat = 0; m_presc = 0; m_phase = 0;
    m_cnt = 0; m_cmp = 'hFFFF; m_lat = 0; m_wb_cnt = 0; m_wb_cmp = 0;
    m_cap = 0; m_cap_lat = 0; m_hist = 0;
  endtask

  function automatic int model_read(input logic [3:0] a);
    case (a)
      4'd0: return m_ctrl;
      4'd1: return m_stat;
      4'd2: return m_presc;
      4'd3: return m_cnt / 256;
      4'd4: return m_lat;
      4'd5: return m_cmp / 256;
      4'd6: return m_cmp % 256;
`ifdef TIMER_CAPTURE_EN
      4'd7: return m_cap / 256;
      4'd8: return m_cap_lat;
`endif
      default: return 0;
    endcase
  endfunction

  function automatic logic model_irq();
    return ((m_stat & 1) != 0 && (m_ctrl & 2) != 0) ||
           ((m_stat & 2) != 0 && (m_ctrl & 4) != 0) ||
           ((m_stat & 4) != 0 && (m_ctrl & 16) != 0);
  endfunction

  // Advance the model across one posedge given the bus values of that cycle.
  task automatic model_step(input logic r, input logic c, input logic w_rw,
                            input logic [3:0] a, input logic [7:0] d);
    logic wr, rd, tick, ocs, tos, ics;
    int   nxt;
    if (r) begin
      model_reset();
      return;
    end
    wr = c && !w_rw;
    rd = c && w_rw;
    tick = ((m_ctrl & 1) != 0) && (m_phase == m_presc);
    ocs = 0; tos = 0; ics = 0;
    if (rd && a == 4'd3) m_lat = m_cnt % 256;
`ifdef TIMER_CAPTURE_EN
    if (rd && a == 4'd7) m_cap_lat = m_cap % 256;
    // Edge seen two edges ago, after the two-stage synchroniser.
    if (((m_hist >> 1) & 1) == 1 && ((m_hist >> 2) & 1) == 0) begin
      m_cap = m_cnt;
      ics = 1;
    end
    m_hist = ((m_hist << 1) | int'(cap_in)) & 7;
`endif
    nxt = (m_cnt + 1) % 65536;
    if (wr && a == 4'd4) begin
      m_cnt = m_wb_cnt * 256 + int'(d);
    end else if (tick) begin
      if (m_cnt == m_cmp) begin
        ocs = 1;
        m_cnt = ((m_ctrl & 8) != 0) ? 0 : nxt;
      end else begin
        if (m_cnt == 65535) tos = 1;
        m_cnt = nxt;
      end
    end
    if (wr && (a == 4'd2 || a == 4'd4)) m_phase = 0;
    else if ((m_ctrl & 1) != 0) m_phase = (m_phase + 1) % (m_presc + 1);
    if (wr && a == 4'd1) m_stat = m_stat & ~int'(d);
    m_stat = m_stat | (ocs ? 1 : 0) | (tos ? 2 : 0) | (ics ? 4 : 0);
    if (wr) begin
      case (a)
        4'd0: m_ctrl = int'(d) & CTRL_MASK_TB;
        4'd2: m_presc = int'(d);
        4'd3: m_wb_cnt = int'(d);
        4'd5: m_wb_cmp = int'(d);
        4'd6: m_cmp = m_wb_cmp * 256 + int'(d);
        default: ;
      endcase
    end
  endtask

  // Driver: one bus cycle, checked against the model before it advances.
  task automatic cyc(input logic r, input logic c, input logic w_rw,
                     input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    rst = r; cs = c; rw = w_rw; Address = a; DI = d;
    #1;
    do_seen  = DO;
    irq_seen = irq;
    check("do", {8'h00, DO}, c ? 16'(model_read(a)) : 16'h0000);
    check("irq", {15'h0, irq}, {15'h0, model_irq()});
    model_step(r, c, w_rw, a, d);
  endtask

  task automatic wr_reg(input logic [3:0] a, input logic [7:0] d);
    cyc(1'b0, 1'b1, 1'b0, a, d);
  endtask

  task automatic rd_reg(input logic [3:0] a);
    cyc(1'b0, 1'b1, 1'b1, a, 8'h00);
  endtask

  task automatic rd_exp(input string tag, input logic [3:0] a, input logic [7:0] exp);
    rd_reg(a);
    check(tag, {8'h00, do_seen}, {8'h00, exp});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b1, 4'd0, 8'h00);
  endtask

  initial begin
    rst = 1'b1; cs = 1'b0; rw = 1'b1; Address = 4'd0; DI = 8'h00;
`ifdef TIMER_CAPTURE_EN
    cap_in = 1'b0;
`endif
    repeat (2) @(posedge clk);
    model_reset();

    // Reset values
    rd_exp("rst_ctrl", 4'd0, 8'h00);
    rd_exp("rst_cnt_h", 4'd3, 8'h00);
    rd_exp("rst_cnt_l", 4'd4, 8'h00);
    rd_exp("rst_cmp_h", 4'd5, 8'hFF);
    rd_exp("rst_cmp_l", 4'd6, 8'hFF);
    rd_exp("rst_cap_h", 4'd7, 8'h00);
    idle(1);
    check("rst_irq", {15'h0, irq_seen}, 16'h0000);

    // Prescaled counting and the low-byte read latch
    wr_reg(4'd2, 8'h03);
    wr_reg(4'd0, 8'h01);
    idle(2);
    rd_exp("presc_cnt_h", 4'd3, 8'h00);
    rd_reg(4'd4);
    wr_reg(4'd3, 8'h00);
    wr_reg(4'd4, 8'hFD);
    rd_reg(4'd3);
    rd_exp("latch_fd", 4'd4, 8'hFD);
    idle(2);
    rd_reg(4'd3);
    rd_exp("latch_fe", 4'd4, 8'hFE);
    for (int i = 0; i < 24; i++) begin
      rd_reg(4'd3);
      rd_reg(4'd4);
    end

    // Compare match with auto-reload
    wr_reg(4'd0, 8'h00);
    wr_reg(4'd2, 8'h00);
    wr_reg(4'd5, 8'h00);
    wr_reg(4'd6, 8'h05);
    wr_reg(4'd3, 8'h00);
    wr_reg(4'd4, 8'h00);
    wr_reg(4'd1, 8'h07);
    wr_reg(4'd0, 8'h0B);
    for (int i = 0; i < 8; i++) begin
      rd_reg(4'd3);
      rd_reg(4'd4);
    end
    idle(1);
    check("ocf_irq", {15'h0, irq_seen}, 16'h0001);
    wr_reg(4'd0, 8'h0A);
    wr_reg(4'd1, 8'h01);
    idle(1);
    check("ocf_clr_irq", {15'h0, irq_seen}, 16'h0000);
    rd_exp("ocf_clr_stat", 4'd1, 8'h00);

    // Overflow, with a coincident write-1-clear of TOF
    wr_reg(4'd0, 8'h00);
    wr_reg(4'd3, 8'hFF);
    wr_reg(4'd4, 8'hFE);
    wr_reg(4'd0, 8'h05);
    idle(1);
    wr_reg(4'd1, 8'h02);
    rd_exp("tof_stat", 4'd1, 8'h02);
    check("tof_irq", {15'h0, irq_seen}, 16'h0001);

    // CNT_L write wins over a coincident tick
    wr_reg(4'd3, 8'h12);
    wr_reg(4'd4, 8'h34);
    rd_exp("ldwin_h", 4'd3, 8'h12);
    rd_exp("ldwin_l", 4'd4, 8'h34);
    check("pre_rst_irq", {15'h0, irq_seen}, 16'h0001);

    // Reset while irq is high
    cyc(1'b1, 1'b0, 1'b1, 4'd0, 8'h00);
    rd_exp("mid_rst_ctrl", 4'd0, 8'h00);
    check("mid_rst_irq", {15'h0, irq_seen}, 16'h0000);
    rd_exp("mid_rst_stat", 4'd1, 8'h00);
    rd_exp("mid_rst_cnt_h", 4'd3, 8'h00);
    rd_exp("mid_rst_cmp_h", 4'd5, 8'hFF);

    // Prescaler restart on CNT_L load
    wr_reg(4'd2, 8'h03);
    wr_reg(4'd0, 8'h01);
    idle(2);
    wr_reg(4'd3, 8'h00);
    wr_reg(4'd4, 8'h40);
    for (int i = 0; i < 10; i++) begin
      rd_reg(4'd3);
      rd_reg(4'd4);
    end

`ifdef TIMER_CAPTURE_EN
    // Input capture on a frozen counter
    wr_reg(4'd0, 8'h00);
    wr_reg(4'd3, 8'h01);
    wr_reg(4'd4, 8'h23);
    wr_reg(4'd1, 8'h07);
    wr_reg(4'd0, 8'h10);
    idle(4);
    cap_in = 1'b1;
    idle(3);
    rd_exp("icf_stat", 4'd1, 8'h04);
    check("icf_irq", {15'h0, irq_seen}, 16'h0001);
    rd_exp("cap_h", 4'd7, 8'h01);
    rd_exp("cap_l", 4'd8, 8'h23);
    cap_in = 1'b0;
`endif

    // Random bus traffic
    for (int n = 0; n < 1500; n++) begin
      int sel;
      sel = $urandom_range(0, 15);
`ifdef TIMER_CAPTURE_EN
      if ($urandom_range(0, 9) == 0) cap_in = ~cap_in;
`endif
      if ($urandom_range(0, 399) == 0) begin
        cyc(1'b1, 1'b0, 1'b1, 4'd0, 8'h00);
      end else if (sel <= 5) begin
        cyc(1'b0, 1'b0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom));
      end else if (sel <= 9) begin
        rd_reg(4'($urandom_range(0, 15)));
      end else if (sel == 10) begin
        wr_reg(4'd0, 8'($urandom));
      end else if (sel == 11) begin
        wr_reg(4'd2, 8'($urandom_range(0, 3)));
      end else if (sel == 12) begin
        wr_reg(4'd1, 8'($urandom));
      end else if (sel == 13) begin
        wr_reg(4'd5, ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00);
        wr_reg(4'd6, 8'($urandom_range(0, 63)));
      end else if (sel == 14) begin
        wr_reg(4'd3, ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00);
        wr_reg(4'd4, 8'($urandom));
      end else begin
        wr_reg(4'($urandom_range(7, 15)), 8'($urandom));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
